// File: rtl/ble_uart_rx.sv
// ble_uart_rx: 8N1 UART receiver for the BLE module link.
// The RX pin is synchronized, a falling edge starts a frame, and the start bit
// is checked at its mid-point. Data bits are then sampled one bit period apart,
// LSB first. A good byte sets a sticky ready flag. A bad stop bit gives a
// one-cycle framing-error pulse. A good byte that lands while ready is still
// set raises a sticky overrun flag.
module ble_uart_rx #(
    parameter int BAUD_CNT = 2604,
    parameter int HALF_CNT = BAUD_CNT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int CW = $clog2(BAUD_CNT);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // rx_pipe_reg[0..1] form the synchronizer, and rx_pipe_reg[2] holds the
    // previous synchronized value for edge detection.
    logic [2:0]    rx_pipe_reg;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shifter_reg;
    logic [7:0]    rx_data_reg;
    logic          rdy_reg;
    logic          frm_err_reg;
    logic          ovr_err_reg;

    logic rx_sync;
    logic rx_fall;

    assign rx_sync = rx_pipe_reg[1];
    // The history flop presets to 1, so a line held low through reset does
    // not look like a falling edge afterwards.
    assign rx_fall = ~rx_pipe_reg[1] & rx_pipe_reg[2];

    // First synchronizer stage: capture the raw pin, idle-high on reset.
    always_ff @(posedge clk) begin
        if (rst)
            rx_pipe_reg[0] <= 1'b1;
        else
            rx_pipe_reg[0] <= RX;
    end

    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_rx_pipe
            // Later synchronizer / history stages, also preset to idle-high.
            always_ff @(posedge clk) begin
                if (rst)
                    rx_pipe_reg[gi] <= 1'b1;
                else
                    rx_pipe_reg[gi] <= rx_pipe_reg[gi-1];
            end
        end
    endgenerate

    // Frame FSM with bit timing, shifting and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shifter_reg <= '0;
            rx_data_reg <= 8'h00;
            rdy_reg     <= 1'b0;
            frm_err_reg <= 1'b0;
            ovr_err_reg <= 1'b0;
        end else begin
            frm_err_reg <= 1'b0;
            // The consumer acknowledge clears the flags. A byte completing
            // in this same cycle overrides it below, so the set wins.
            if (clr_rdy) begin
                rdy_reg     <= 1'b0;
                ovr_err_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (rx_fall) begin
                        cnt_reg   <= HALF_LOAD;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (cnt_reg == '0) begin
                        if (!rx_sync) begin
                            cnt_reg     <= BAUD_LOAD;
                            bit_idx_reg <= 3'd0;
                            state_reg   <= DATA;
                        end else begin
                            // Line back high at mid-start: treat it as a glitch.
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == '0) begin
                        shifter_reg <= {rx_sync, shifter_reg[7:1]};
                        cnt_reg     <= BAUD_LOAD;
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7)
                            state_reg <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        if (rx_sync) begin
                            rx_data_reg <= shifter_reg;
                            rdy_reg     <= 1'b1;
                            if (rdy_reg && !clr_rdy)
                                ovr_err_reg <= 1'b1;
                        end else begin
                            frm_err_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_reg;
    assign rdy     = rdy_reg;
    assign frm_err = frm_err_reg;
    assign ovr_err = ovr_err_reg;

endmodule

// File: tb/tb_ble_uart_rx.sv
// tb_ble_uart_rx: directed and randomized frames for ble_uart_rx, checked
// against a frame-level model of the receiver's flags and data.
module tb_ble_uart_rx;

    localparam int BAUD = 16;
    localparam int HALF = BAUD / 2;
    // The edge index (counted from the first edge after RX changes) at which
    // the stop bit is sampled. It is the 2-flop synchronizer delay plus the
    // mid-start offset plus nine bit periods.
    localparam int SAMPLE_S = 2 + HALF + 9 * BAUD;
    localparam int FRAME_S  = 10 * BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference state.
    logic [7:0] m_data = 8'h00;
    logic       m_rdy  = 1'b0;
    logic       m_ovr  = 1'b0;

    ble_uart_rx #(.BAUD_CNT(BAUD)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
        check({tag, ".rdy"},     32'(rdy),     32'(m_rdy));
        check({tag, ".ovr_err"}, 32'(ovr_err), 32'(m_ovr));
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        clr_rdy = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_clr(input string tag);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        check({tag, ".clr_rdy"}, 32'(rdy), 32'(0));
        check({tag, ".clr_ovr"}, 32'(ovr_err), 32'(0));
    endtask

    // Drive one frame. clr_tick / rst_tick name the edge index at which
    // clr_rdy / rst are high for one cycle (-1 for none). The outputs are
    // sampled on the falling edge after each rising edge.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic stop,
                              input int clr_tick, input int rst_tick);
        logic [9:0] bits;
        int frm_cnt;
        int frm_first;
        int rdy_first;
        int exp_rise;
        logic rdy_prev;
        logic rdy_before;
        bits = {stop, b, 1'b0};
        frm_cnt = 0;
        frm_first = -1;
        rdy_first = -1;
        rdy_prev = rdy;
        rdy_before = m_rdy;
        for (int s = 0; s < FRAME_S; s++) begin
            RX = bits[s / BAUD];
            clr_rdy = (s == clr_tick);
            rst = (s == rst_tick);
            @(negedge clk);
            if (s == rst_tick) begin
                rst = 1'b0;
                RX = 1'b1;
                clr_rdy = 1'b0;
                m_data = 8'h00;
                m_rdy = 1'b0;
                m_ovr = 1'b0;
                check({tag, ".rst_frm"}, 32'(frm_err), 32'(0));
                check_state({tag, ".rst"});
                return;
            end
            if (frm_err) begin
                frm_cnt++;
                if (frm_first < 0) frm_first = s + 1;
            end
            if (rdy && !rdy_prev && rdy_first < 0) rdy_first = s + 1;
            rdy_prev = rdy;
        end
        clr_rdy = 1'b0;
        RX = 1'b1;

        // Reference update, in time order of the events within the frame.
        if (clr_tick >= 0 && clr_tick < SAMPLE_S) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
        exp_rise = (stop && (!rdy_before || (clr_tick >= 0 && clr_tick < SAMPLE_S)))
                   ? SAMPLE_S + 1 : -1;
        if (stop) begin
            if (clr_tick == SAMPLE_S) m_ovr = 1'b0;
            else if (m_rdy) m_ovr = 1'b1;
            m_rdy = 1'b1;
            m_data = b;
        end else if (clr_tick == SAMPLE_S) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
        if (clr_tick > SAMPLE_S) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end

        check({tag, ".frm_cnt"}, 32'(frm_cnt), stop ? 32'(0) : 32'(1));
        if (!stop) check({tag, ".frm_lat"}, 32'(frm_first), 32'(SAMPLE_S + 1));
        check({tag, ".rdy_rise"}, 32'(rdy_first), 32'(exp_rise));
        check_state(tag);
    endtask

    initial begin
        int frm_seen;
        int rdy_seen;
        logic [7:0] rb;
        logic rstop;
        int rclr;
        int sel;

        // Reset held for a few cycles while the line idles.
        rst = 1'b1;
        RX = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("reset.frm_err", 32'(frm_err), 32'(0));
        check_state("reset");
        rst = 1'b0;
        idle(5);

        // 1: good byte, then an acknowledge.
        send_frame("t1_a5", 8'hA5, 1'b1, -1, -1);
        pulse_clr("t1");
        idle(3);

        // 2: bad stop bit.
        send_frame("t2_3c", 8'h3C, 1'b0, -1, -1);
        idle(4);

        // 3: a short low glitch must be rejected at the start-bit sample.
        frm_seen = 0;
        rdy_seen = 0;
        RX = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        RX = 1'b1;
        for (int i = 0; i < 3 * BAUD; i++) begin
            @(negedge clk);
            if (frm_err) frm_seen++;
            if (rdy) rdy_seen++;
        end
        check("t3_glitch.frm", 32'(frm_seen), 32'(0));
        check("t3_glitch.rdy", 32'(rdy_seen), 32'(0));
        send_frame("t3_81", 8'h81, 1'b1, -1, -1);
        pulse_clr("t3");
        idle(2);

        // 4: two bytes back to back without an acknowledge.
        send_frame("t4_00", 8'h00, 1'b1, -1, -1);
        send_frame("t4_ff", 8'hFF, 1'b1, -1, -1);
        pulse_clr("t4");
        idle(2);

        // 6: clr_rdy lands in the exact cycle a second byte completes.
        send_frame("t6_34", 8'h34, 1'b1, -1, -1);
        send_frame("t6_12", 8'h12, 1'b1, SAMPLE_S, -1);
        idle(2);

        // 5: reset in the middle of data bit 4, then a clean byte.
        send_frame("t5_55", 8'h55, 1'b1, -1, 5 * BAUD + 8);
        idle(2 * BAUD);
        send_frame("t5_c3", 8'hC3, 1'b1, -1, -1);
        idle(2);

        // Randomized frames with random stop bits, acknowledges and gaps.
        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 4) != 0);
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: rclr = -1;
                1: rclr = int'($urandom_range(0, SAMPLE_S - 1));
                2: rclr = SAMPLE_S;
                default: rclr = int'($urandom_range(SAMPLE_S + 1, FRAME_S - 1));
            endcase
            send_frame($sformatf("rnd%0d_%02h", n, rb), rb, rstop, rclr, -1);
            idle(rstop ? int'($urandom_range(0, 3)) : int'($urandom_range(3, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ble_uart_rx.md
Name: ble_uart_rx

Overview:
- Serial receiver for the BLE module link: 8N1 asynchronous UART deserializer that sits directly upstream of the authentication block and feeds it received command bytes.
- Synchronizes the raw RX pin, detects and qualifies start bits, samples mid-bit, and presents each byte with a sticky ready flag and a clear handshake.
- Also reports framing errors and overrun errors so the authentication logic can discard corrupted commands.

Parameters:
- BAUD_CNT, 2604, clk cycles per bit (50 MHz / 19200 baud); minimum 4.
- HALF_CNT, BAUD_CNT/2, cycles from start-bit detect to the start-bit mid-point sample.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- RX  input  1  raw asynchronous serial input from the BLE module; idle high.
- clr_rdy  input  1  consumer acknowledge; clears rdy and ovr_err.
- rx_data  output  8  last good byte received, LSB first on the wire.
- rdy  output  1  sticky; a new good byte is in rx_data.
- frm_err  output  1  one-cycle pulse when a frame ends with stop bit = 0.
- ovr_err  output  1  sticky; a good byte completed while rdy was already high.

Behaviour:
- Reset and synchronizer:
  - Reset is synchronous, active-high, and takes effect on any cycle, including mid-frame.
  - Reset values: rx_data=8'h00, rdy=0, frm_err=0, ovr_err=0, FSM=IDLE, counters=0.
  - RX passes through a 2-flop synchronizer plus one history flop; all three preset to 1 on reset.
  - Start detection fires only on a 1->0 edge of the synchronized RX, so a line held low through reset does not start a frame.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a synchronized falling edge (detect cycle), load the baud counter with HALF_CNT-1 and go to START.
- START:
  - Decrement the counter. When it reaches 0, sample RX.
  - RX=0: load BAUD_CNT-1, clear the bit index, go to DATA.
  - RX=1: treat as a glitch / false start; return to IDLE, with no output change.
- DATA:
  - On each counter expiry, shift the sampled bit into bit 7 of the shift register (right shift, LSB first) and reload BAUD_CNT-1.
  - After the 8th sample, go to STOP.
- STOP, on counter expiry:
  - RX=1: the cycle after this sample, rx_data<=shift register and rdy<=1. If rdy was already 1 and clr_rdy is not asserted that cycle, ovr_err<=1 and rx_data is still overwritten.
  - RX=0: the cycle after this sample, frm_err pulses high for one cycle; rx_data and rdy are unchanged.
  - Either way, return to IDLE. A new start edge can be accepted the cycle after the stop sample.
- Latency: rdy rises 1 cycle after the stop-bit sample, which is HALF_CNT + 9*BAUD_CNT cycles after the detect cycle.
- Handshake:
  - clr_rdy clears rdy and ovr_err on the next edge.
  - If clr_rdy and a byte completion land in the same cycle, set wins: rdy=1, and ovr_err is not set.
- clr_rdy while idle with rdy=0: no effect.
- The receiver never blocks; bytes arriving during rdy=1 are still received.
- All outputs are registered; there are no combinational paths from RX or clr_rdy to any output.

Test Plan:
All tests use BAUD_CNT=16 and drive the RX frame bit-by-bit at 16 cycles per bit.
1. Send 8'hA5 with a good stop bit -> rdy rises 1 cycle after the stop sample, rx_data=8'hA5, ovr_err=0. Pulse clr_rdy -> rdy=0 on the next cycle.
2. Send 8'h3C with stop bit=0 -> frm_err is high for exactly 1 cycle; rdy stays 0; rx_data keeps its previous value.
3. Hold RX low for 4 cycles, then high -> FSM returns to IDLE at the start sample; no rdy, no frm_err. A following 8'h81 is then received correctly.
4. Send 8'h00, do not clear, then 8'hFF back-to-back -> rx_data=8'hFF, rdy=1, ovr_err=1. After clr_rdy, both are 0.
5. Assert rst during DATA bit 4 of 8'h55 -> all outputs are at reset values the next cycle. A following 8'hC3 is received correctly with no spurious byte.
6. Assert clr_rdy in the exact cycle a second byte 8'h12 completes while rdy=1 -> rdy=1, rx_data=8'h12, ovr_err=0.
